neuron_feeder: RTL and testbench
================================

NEURON_FEEDER -- requirements
Module: neuron_feeder

Interface
REQ-001 Parameter DATA_W, default 16: operand width, signed Q8.8 fixed point.
REQ-002 Parameter DEPTH, default 16: operand-pair buffer entries; ADDR_W = clog2(DEPTH).
REQ-003 Parameter NRN_LAT, default 1: cycles from the neuron's mac cycle to a valid n_out.
REQ-004 clk  in  1  system clock; all logic on its rising edge.
REQ-005 rst  in  1  synchronous, active-low reset.
REQ-006 wr_en  in  1  write one operand pair into the buffer.
REQ-007 wr_addr  in  ADDR_W  buffer entry to write.
REQ-008 wr_in, wr_wgh  in  DATA_W each  input value and weight to store.
REQ-009 bias_we, bias_in  in  1, DATA_W  load the bias register.
REQ-010 len  in  ADDR_W+1  number of pairs to stream; sampled when start is accepted.
REQ-011 start  in  1  request one neuron evaluation.
REQ-012 busy  out  1  high in every state except IDLE.
REQ-013 err  out  1  one-cycle pulse when start is rejected.
REQ-014 nrn_clr, nrn_en, nrn_mac  out  1 each  neuron accumulator clear, enable, and bias/finish strobe.
REQ-015 nrn_in, nrn_wgh, nrn_bias  out  DATA_W each  neuron operands.
REQ-016 nrn_out  in  DATA_W  neuron result.
REQ-017 res, res_valid  out  DATA_W, 1  captured result and its valid flag.
REQ-018 res_ready  in  1  consumer accepts res.

Function
REQ-019 FSM states SHALL be IDLE, CLEAR, STREAM, BIAS, WAIT, HOLD.
REQ-020 IDLE: start with 1<=len<=DEPTH latches len and moves to CLEAR; if len=0 or len>DEPTH, err pulses for 1 cycle and the FSM stays in IDLE.
REQ-021 CLEAR: exactly 1 cycle, nrn_clr=1, then STREAM with idx=0.
REQ-022 STREAM: len cycles with nrn_en=1 and nrn_mac=0; nrn_in/nrn_wgh = buffer[idx]; idx increments each cycle; leaves for BIAS when idx=len-1.
REQ-023 BIAS: 1 cycle with nrn_en=1, nrn_mac=1 and nrn_bias = bias register; nrn_in/nrn_wgh = 0.
REQ-024 WAIT: NRN_LAT cycles; on the last cycle, nrn_out is captured into res and the FSM moves to HOLD with res_valid=1.
REQ-025 res_valid SHALL first be high exactly len+NRN_LAT+2 cycles after the edge that accepted start.
REQ-026 HOLD: res and res_valid stay stable until res_ready=1, then return to IDLE with res_valid=0 on the next cycle.
REQ-027 res_ready may already be high when res_valid rises; the handshake then completes in that cycle.
REQ-028 Outside the CLEAR/STREAM/BIAS states, nrn_clr, nrn_en and nrn_mac SHALL be 0 and nrn_in, nrn_wgh and nrn_bias SHALL be 0.
REQ-029 start is ignored while busy=1 and SHALL NOT pulse err.
REQ-030 wr_en and bias_we are honoured only in IDLE; while busy they are ignored so the buffers are frozen.
REQ-031 A write and an accepted start in the same IDLE cycle: the write completes, and streaming uses the new value.
REQ-032 The feeder SHALL perform no arithmetic; operands pass through bit-exact.

Reset
REQ-033 On rst=0 at a clock edge: FSM to IDLE, idx=0, len register=0, and every output 0 (busy, err, nrn_*, res, res_valid).
REQ-034 Reset mid-operation aborts immediately; no nrn_mac or res_valid follows.
REQ-035 Buffer and bias register contents are not reset.

Structure
REQ-036 Shared package nn_pkg SHALL hold DATA_W, FRAC_W=8, DEPTH and the feeder state enum.
REQ-037 One sub-module operand_buf SHALL provide the DEPTH x (2*DATA_W) register file: one synchronous write port and one combinational read port.

Verification
REQ-038 Load pairs (0x0280, 0x0080) and (0x0380, 0x0100), bias 0x0080, len=2, start, with a behavioural neuron (NRN_LAT=1):
- res=0x0540 (5.25);
- res_valid high 5 cycles after start;
- nrn_mac high for exactly 1 cycle.
REQ-039 start with len=0, then with len=17 -> err pulses once each; busy and nrn_en stay 0.
REQ-040 len=16 with all pairs (0x0100, 0x0100), bias 0 -> 16 STREAM cycles; res=0x1000.
REQ-041 Hold res_ready=0 for 5 cycles after res_valid -> res stable; start and wr_en during HOLD ignored; result released on res_ready=1.
REQ-042 rst=0 during the 2nd STREAM cycle -> all outputs 0 next cycle; a following run with len=1 (0x0200, 0x0200), bias 0 gives res=0x0400.
REQ-043 Write and start in the same IDLE cycle at addr 0 with value 0x0300 -> nrn_in=0x0300 in the first STREAM cycle.

Source files
------------

// File: rtl/nn_pkg.sv
`default_nettype none
// ============================================================================
// Module   : nn_pkg
// Brief    : Shared operand format, buffer depth and feeder state encoding.
// Revision : 1.0  initial release
// ============================================================================
package nn_pkg;

    localparam int DATA_W = 16;
    localparam int FRAC_W = 8;
    localparam int DEPTH  = 16;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_CLEAR  = 3'd1,
        ST_STREAM = 3'd2,
        ST_BIAS   = 3'd3,
        ST_WAIT   = 3'd4,
        ST_HOLD   = 3'd5
    } feeder_state_e;

endpackage
`default_nettype wire

// File: rtl/operand_buf.sv
`default_nettype none
// ============================================================================
// Module   : operand_buf
// Brief    : DEPTH x (input,weight) register file, sync write, async read.
// Revision : 1.0  initial release
// ============================================================================
module operand_buf #(
    parameter int DATA_W = nn_pkg::DATA_W,
    parameter int DEPTH  = nn_pkg::DEPTH,
    parameter int ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic              clk,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [DATA_W-1:0] win_i,
    input  logic [DATA_W-1:0] wwgh_i,
    input  logic [ADDR_W-1:0] raddr_i,
    output logic [DATA_W-1:0] rin_o,
    output logic [DATA_W-1:0] rwgh_o
);
    import nn_pkg::*;

    // Contents deliberately survive reset.
    logic [2*DATA_W-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= {win_i, wwgh_i};
        end
    end

    assign {rin_o, rwgh_o} = mem_q[raddr_i];

endmodule
`default_nettype wire

// File: rtl/neuron_feeder.sv
`default_nettype none
// ============================================================================
// Module   : neuron_feeder
// Brief    : Streams buffered operand pairs and a bias into a neuron, then
//            holds the neuron result behind a valid/ready handshake.
// Revision : 1.0  initial release
// ============================================================================
module neuron_feeder #(
    parameter  int DATA_W  = nn_pkg::DATA_W,
    parameter  int DEPTH   = nn_pkg::DEPTH,
    parameter  int NRN_LAT = 1,
    localparam int ADDR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_in,
    input  logic [DATA_W-1:0] wr_wgh,
    input  logic              bias_we,
    input  logic [DATA_W-1:0] bias_in,
    input  logic [ADDR_W:0]   len,
    input  logic              start,
    output logic              busy,
    output logic              err,
    output logic              nrn_clr,
    output logic              nrn_en,
    output logic              nrn_mac,
    output logic [DATA_W-1:0] nrn_in,
    output logic [DATA_W-1:0] nrn_wgh,
    output logic [DATA_W-1:0] nrn_bias,
    input  logic [DATA_W-1:0] nrn_out,
    output logic [DATA_W-1:0] res,
    output logic              res_valid,
    input  logic              res_ready
);
    import nn_pkg::*;

    localparam int              LAT_W   = (NRN_LAT > 1) ? $clog2(NRN_LAT) : 1;
    localparam logic [ADDR_W:0] LEN_MAX = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0] LEN_ONE = (ADDR_W + 1)'(1);

    feeder_state_e     state_q, state_d;
    logic [ADDR_W-1:0] idx_q, idx_d;
    logic [ADDR_W:0]   len_q, len_d;
    logic [LAT_W-1:0]  wcnt_q, wcnt_d;
    logic              err_q, err_d;
    logic [DATA_W-1:0] res_q, res_d;
    logic              res_valid_q, res_valid_d;
    logic [DATA_W-1:0] bias_q;

    logic              w_idle;
    logic              w_len_ok;
    logic [DATA_W-1:0] w_rd_in;
    logic [DATA_W-1:0] w_rd_wgh;

    assign w_idle   = (state_q == ST_IDLE);
    assign w_len_ok = (len != '0) && (len <= LEN_MAX);

    // Writes are gated to IDLE so the operands cannot change under a run.
    operand_buf #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_buf (
        .clk     (clk),
        .we_i    (wr_en && w_idle),
        .waddr_i (wr_addr),
        .win_i   (wr_in),
        .wwgh_i  (wr_wgh),
        .raddr_i (idx_q),
        .rin_o   (w_rd_in),
        .rwgh_o  (w_rd_wgh)
    );

    always_ff @(posedge clk) begin
        if (bias_we && w_idle) begin
            bias_q <= bias_in;
        end
    end

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        len_d       = len_q;
        wcnt_d      = wcnt_q;
        err_d       = 1'b0;
        res_d       = res_q;
        res_valid_d = res_valid_q;
        nrn_clr     = 1'b0;
        nrn_en      = 1'b0;
        nrn_mac     = 1'b0;
        nrn_in      = '0;
        nrn_wgh     = '0;
        nrn_bias    = '0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (w_len_ok) begin
                        len_d   = len;
                        state_d = ST_CLEAR;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            ST_CLEAR: begin
                nrn_clr = 1'b1;
                idx_d   = '0;
                state_d = ST_STREAM;
            end
            ST_STREAM: begin
                nrn_en  = 1'b1;
                nrn_in  = w_rd_in;
                nrn_wgh = w_rd_wgh;
                if ({1'b0, idx_q} == (len_q - LEN_ONE)) begin
                    idx_d   = '0;
                    state_d = ST_BIAS;
                end else begin
                    idx_d = idx_q + ADDR_W'(1);
                end
            end
            ST_BIAS: begin
                nrn_en   = 1'b1;
                nrn_mac  = 1'b1;
                nrn_bias = bias_q;
                wcnt_d   = '0;
                state_d  = ST_WAIT;
            end
            ST_WAIT: begin
                if (wcnt_q == LAT_W'(NRN_LAT - 1)) begin
                    res_d       = nrn_out;
                    res_valid_d = 1'b1;
                    state_d     = ST_HOLD;
                end else begin
                    wcnt_d = wcnt_q + LAT_W'(1);
                end
            end
            ST_HOLD: begin
                if (res_ready) begin
                    res_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            idx_q       <= '0;
            len_q       <= '0;
            wcnt_q      <= '0;
            err_q       <= 1'b0;
            res_q       <= '0;
            res_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            len_q       <= len_d;
            wcnt_q      <= wcnt_d;
            err_q       <= err_d;
            res_q       <= res_d;
            res_valid_q <= res_valid_d;
        end
    end

    assign busy      = !w_idle;
    assign err       = err_q;
    assign res       = res_q;
    assign res_valid = res_valid_q;

endmodule
`default_nettype wire

// File: tb/tb_neuron_feeder.sv
`default_nettype none
// ============================================================================
// Module   : tb_neuron_feeder
// Brief    : Scoreboard bench for neuron_feeder with a behavioural Q8.8 neuron.
// Revision : 1.0  initial release
// ============================================================================
module tb_neuron_feeder;

    logic        clk = 1'b0;
    logic        rst;
    logic        wr_en;
    logic [3:0]  wr_addr;
    logic [15:0] wr_in, wr_wgh;
    logic        bias_we;
    logic [15:0] bias_in;
    logic [4:0]  len;
    logic        start;
    logic        busy, err, nrn_clr, nrn_en, nrn_mac;
    logic [15:0] nrn_in, nrn_wgh, nrn_bias;
    logic [15:0] nrn_out = 16'h0;
    logic [15:0] res;
    logic        res_valid;
    logic        res_ready;

    neuron_feeder #(.DATA_W(16), .DEPTH(16), .NRN_LAT(1)) dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_in(wr_in),
        .wr_wgh(wr_wgh), .bias_we(bias_we), .bias_in(bias_in), .len(len),
        .start(start), .busy(busy), .err(err), .nrn_clr(nrn_clr),
        .nrn_en(nrn_en), .nrn_mac(nrn_mac), .nrn_in(nrn_in), .nrn_wgh(nrn_wgh),
        .nrn_bias(nrn_bias), .nrn_out(nrn_out), .res(res),
        .res_valid(res_valid), .res_ready(res_ready)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [15:0][15:0] din;
        logic [15:0][15:0] wgh;
        logic [15:0]       bias;
        logic [15:0]       res;
        int                len;
        int                t0;
    } exp_t;

    exp_t        sb_q[$];
    logic [15:0] mem_din [16];
    logic [15:0] mem_wgh [16];
    logic [15:0] bias_m;
    int          n_cmp = 0, n_bad = 0;
    int          cyc = 0;
    int          exp_err = 0, seen_err = 0;
    int          ready_mode = 1;
    logic [15:0] last_res = 16'h0, first_in = 16'h0;

    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural neuron: Q8.8 products summed, bias added, one cycle latency.
    int acc_n = 0;
    always @(posedge clk) begin
        if (nrn_clr)
            acc_n <= 0;
        else if (nrn_en && !nrn_mac)
            acc_n <= acc_n + ((int'($signed(nrn_in)) * int'($signed(nrn_wgh))) >>> 8);
        else if (nrn_en && nrn_mac)
            nrn_out <= 16'(acc_n + int'($signed(nrn_bias)));
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h required 0x%0h", nm, act, exp);
        end
    endtask

    function automatic logic [15:0] ref_res(input exp_t e);
        int acc = 0;
        for (int i = 0; i < e.len; i++)
            acc += (int'($signed(e.din[i])) * int'($signed(e.wgh[i]))) >>> 8;
        acc += int'($signed(e.bias));
        return 16'(acc);
    endfunction

    initial forever begin
        @(negedge clk);
        res_ready = (ready_mode == 1) ? 1'b1 :
                    (ready_mode == 2) ? 1'b0 : 1'($urandom_range(0, 1));
    end

    // Monitor / scoreboard
    int          sidx = 0, mac_cnt = 0;
    logic        prev_valid = 1'b0;
    logic [15:0] prev_res = 16'h0;
    always @(negedge clk) begin
        exp_t e;
        if (err) seen_err++;
        if (!busy)
            chk("idle_nrn_zero", {nrn_clr, nrn_en, nrn_mac, nrn_in, nrn_wgh, nrn_bias}, 64'h0);
        if (nrn_clr) begin
            sidx = 0;
            mac_cnt = 0;
            chk("clr_alone", {nrn_en, nrn_mac}, 64'h0);
        end
        if (nrn_en && !nrn_mac) begin
            if (sb_q.size() == 0 || sidx > 15)
                chk("stream_unexpected", {nrn_en, sidx[4:0]}, 64'h0);
            else begin
                chk("stream_in", nrn_in, sb_q[0].din[sidx]);
                chk("stream_wgh", nrn_wgh, sb_q[0].wgh[sidx]);
                if (sidx == 0) first_in = nrn_in;
            end
            sidx++;
        end
        if (nrn_mac) begin
            mac_cnt++;
            chk("bias_en", nrn_en, 1);
            chk("bias_ops_zero", {nrn_in, nrn_wgh}, 64'h0);
            if (sb_q.size() != 0) chk("bias_val", nrn_bias, sb_q[0].bias);
        end
        if (res_valid && !prev_valid) begin
            if (sb_q.size() == 0)
                chk("res_unexpected", res_valid, 0);
            else begin
                e = sb_q.pop_front();
                chk("res", res, e.res);
                chk("latency", cyc - e.t0, e.len + 3);
                chk("mac_once", mac_cnt, 1);
                chk("stream_cycles", sidx, e.len);
                last_res = res;
            end
        end else if (res_valid && prev_valid) begin
            chk("hold_stable", res, prev_res);
        end
        prev_valid = res_valid;
        prev_res = res;
    end

    task automatic write_pair(input int a, input logic [15:0] di, input logic [15:0] wi);
        wr_en = 1'b1; wr_addr = a[3:0]; wr_in = di; wr_wgh = wi;
        mem_din[a] = di; mem_wgh[a] = wi;
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    task automatic set_bias(input logic [15:0] b);
        bias_we = 1'b1; bias_in = b; bias_m = b;
        @(negedge clk);
        bias_we = 1'b0;
    endtask

    task automatic start_run(input int l, input bit do_wr, input int a,
                             input logic [15:0] di, input logic [15:0] wi);
        exp_t e;
        if (do_wr) begin
            wr_en = 1'b1; wr_addr = a[3:0]; wr_in = di; wr_wgh = wi;
            mem_din[a] = di; mem_wgh[a] = wi;
        end
        start = 1'b1;
        len = l[4:0];
        if (l >= 1 && l <= 16) begin
            e = '0;
            e.len = l;
            e.t0 = cyc + 1;
            e.bias = bias_m;
            for (int i = 0; i < 16; i++) begin
                e.din[i] = mem_din[i];
                e.wgh[i] = mem_wgh[i];
            end
            e.res = ref_res(e);
            sb_q.push_back(e);
            @(negedge clk);
            start = 1'b0; wr_en = 1'b0;
        end else begin
            exp_err++;
            @(negedge clk);
            start = 1'b0; wr_en = 1'b0;
            chk("err_pulse", err, 1);
            chk("busy_after_reject", busy, 0);
            @(negedge clk);
            chk("err_one_cycle", err, 0);
        end
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk("run_done", busy, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no finish, required finish within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int nw, l;
        rst = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_in = '0; wr_wgh = '0;
        bias_we = 1'b0; bias_in = '0; len = '0; start = 1'b0; bias_m = '0;
        repeat (3) @(negedge clk);
        chk("rst_ctrl", {busy, err, nrn_clr, nrn_en, nrn_mac, res_valid}, 64'h0);
        chk("rst_data", {nrn_in, nrn_wgh, nrn_bias, res}, 64'h0);
        rst = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 16; i++) write_pair(i, 16'h0, 16'h0);
        set_bias(16'h0);

        // Worked example: 2.5*0.5 + 3.5*1.0 + 0.5 = 5.25
        ready_mode = 1;
        write_pair(0, 16'h0280, 16'h0080);
        write_pair(1, 16'h0380, 16'h0100);
        set_bias(16'h0080);
        start_run(2, 0, 0, 16'h0, 16'h0);
        wait_idle();
        chk("ex_res", last_res, 16'h0540);

        // Illegal lengths
        start_run(0, 0, 0, 16'h0, 16'h0);
        start_run(17, 0, 0, 16'h0, 16'h0);

        // Full depth, all ones
        for (int i = 0; i < 16; i++) write_pair(i, 16'h0100, 16'h0100);
        set_bias(16'h0);
        start_run(16, 0, 0, 16'h0, 16'h0);
        wait_idle();
        chk("full_res", last_res, 16'h1000);

        // Backpressure: HOLD with writes and start attempted
        ready_mode = 2;
        start_run(2, 0, 0, 16'h0, 16'h0);
        nw = 0;
        while (!res_valid && nw < 100) begin
            @(negedge clk);
            nw++;
        end
        chk("hold_reached", res_valid, 1);
        @(negedge clk);
        start = 1'b1; len = 5'd1;
        wr_en = 1'b1; wr_addr = 4'd0; wr_in = 16'h7777; wr_wgh = 16'h7777;
        bias_we = 1'b1; bias_in = 16'h5555;
        @(negedge clk);
        start = 1'b0; wr_en = 1'b0; bias_we = 1'b0;
        repeat (3) @(negedge clk);
        chk("hold_busy", {busy, res_valid}, 2'b11);
        chk("hold_res", res, 16'h0200);
        ready_mode = 1;
        wait_idle();
        chk("hold_released", res_valid, 0);
        start_run(3, 0, 0, 16'h0, 16'h0);
        wait_idle();
        chk("frozen_buf_res", last_res, 16'h0300);

        // Randomised runs
        for (int r = 0; r < 40; r++) begin
            nw = $urandom_range(0, 3);
            for (int k = 0; k < nw; k++)
                write_pair($urandom_range(0, 15), 16'($urandom), 16'($urandom));
            if ($urandom_range(0, 3) == 0) set_bias(16'($urandom));
            ready_mode = ($urandom_range(0, 2) == 0) ? 1 : 0;
            if ($urandom_range(0, 7) == 0) begin
                l = ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(17, 31);
                start_run(l, 0, 0, 16'h0, 16'h0);
            end else begin
                start_run($urandom_range(1, 16), ($urandom_range(0, 2) == 0),
                          $urandom_range(0, 15), 16'($urandom), 16'($urandom));
            end
            wait_idle();
        end

        // Reset during the second STREAM cycle
        ready_mode = 1;
        start_run(3, 0, 0, 16'h0, 16'h0);
        @(negedge clk);
        @(negedge clk);
        chk("abort_in_stream", {nrn_en, nrn_mac}, 2'b10);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        chk("abort_ctrl", {busy, err, nrn_clr, nrn_en, nrn_mac, res_valid}, 64'h0);
        chk("abort_data", {nrn_in, nrn_wgh, nrn_bias, res}, 64'h0);
        sb_q.delete();
        repeat (6) begin
            @(negedge clk);
            chk("abort_quiet", {nrn_mac, res_valid, busy}, 64'h0);
        end
        write_pair(0, 16'h0200, 16'h0200);
        set_bias(16'h0);
        start_run(1, 0, 0, 16'h0, 16'h0);
        wait_idle();
        chk("after_abort_res", last_res, 16'h0400);

        // Write and start in the same IDLE cycle
        start_run(2, 1, 0, 16'h0300, 16'h0100);
        wait_idle();
        chk("same_cycle_first_in", first_in, 16'h0300);

        repeat (3) @(negedge clk);
        chk("err_count", seen_err, exp_err);
        chk("sb_empty", sb_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
